// File: rtl/serpent_arbiter_if.sv
// Requester, key, cipher-core and response signals around serpent_arbiter.
// The arbiter takes the slave modport; the environment drives the master side.
interface serpent_arbiter_if;
  logic         i_req0_valid;
  logic         i_req0_dir;
  logic [127:0] i_req0_data;
  logic         o_req0_ready;
  logic         i_req1_valid;
  logic         i_req1_dir;
  logic [127:0] i_req1_data;
  logic         o_req1_ready;
  logic         i_key_valid;
  logic [255:0] i_key;
  logic         o_key_ready;
  logic [127:0] o_core_data;
  logic [255:0] o_core_key;
  logic         o_core_dir;
  logic [127:0] i_core_result;
  logic         o_rsp_valid;
  logic         o_rsp_id;
  logic [127:0] o_rsp_data;
  logic         i_rsp_ready;

  modport slave (
    input  i_req0_valid, i_req0_dir, i_req0_data,
    input  i_req1_valid, i_req1_dir, i_req1_data,
    input  i_key_valid, i_key, i_core_result, i_rsp_ready,
    output o_req0_ready, o_req1_ready, o_key_ready,
    output o_core_data, o_core_key, o_core_dir,
    output o_rsp_valid, o_rsp_id, o_rsp_data
  );

  modport master (
    output i_req0_valid, i_req0_dir, i_req0_data,
    output i_req1_valid, i_req1_dir, i_req1_data,
    output i_key_valid, i_key, i_core_result, i_rsp_ready,
    input  o_req0_ready, o_req1_ready, o_key_ready,
    input  o_core_data, o_core_key, o_core_dir,
    input  o_rsp_valid, o_rsp_id, o_rsp_data
  );
endinterface

// File: rtl/serpent_arbiter.sv
// Two-requester round-robin front end for a fixed-latency Serpent core, with
// key-change draining, a tag pipeline tracking in-flight blocks and a result FIFO.
module serpent_arbiter #(
  parameter int LAT     = 34,
  parameter int DEPTH   = 64,
  parameter int KEY_LAT = 2
) (
  input logic              i_clk,
  input logic              i_reset,
  serpent_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(LAT + 2);
  localparam int OW = (((AW + 1) > IW) ? (AW + 1) : IW) + 1;

  typedef enum logic [1:0] {NOKEY, RUN, DRAIN, SETTLE} state_t;

  typedef struct packed {
    logic         id;
    logic [127:0] data;
  } rsp_t;

  state_t        state;
  state_t        state_next;
  logic          key_ready;
  logic          key_hs;
  logic          load_key_input;
  logic          load_key_pending;
  logic          capture_pending;
  logic [3:0]    settle_cnt;
  logic [255:0]  core_key;
  logic [255:0]  pending_key;

  logic          issue_en;
  logic          grant;
  logic          last_grant;
  logic          accept;
  logic          accept_dir;
  logic [127:0]  accept_data;
  logic [127:0]  core_data;

  // Stage 0 travels alongside o_core_data; stage LAT lines up with i_core_result.
  logic [LAT:0]  tag_valid;
  logic [LAT:0]  tag_id;
  logic [LAT:0]  tag_dir;
  logic [IW-1:0] inflight;

  rsp_t          fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_count;
  logic          push;
  logic          pop;
  logic          rsp_valid;
  logic [OW-1:0] occupancy;

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    state_next       = state;
    key_ready        = 1'b0;
    load_key_input   = 1'b0;
    load_key_pending = 1'b0;
    capture_pending  = 1'b0;
    case (state)
      NOKEY: begin
        key_ready = 1'b1;
        if (bus.i_key_valid) begin
          load_key_input = 1'b1;
          state_next     = SETTLE;
        end
      end
      RUN: begin
        key_ready = 1'b1;
        if (bus.i_key_valid) begin
          capture_pending = 1'b1;
          if (inflight != '0) begin
            state_next = DRAIN;
          end else begin
            load_key_input = 1'b1;
            state_next     = SETTLE;
          end
        end
      end
      DRAIN: begin
        if (inflight == '0) begin
          load_key_pending = 1'b1;
          state_next       = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) state_next = RUN;
      end
      default: state_next = NOKEY;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= NOKEY;
      settle_cnt  <= 4'(KEY_LAT - 1);
      core_key    <= '0;
      pending_key <= '0;
    end else begin
      state <= state_next;
      if (state != SETTLE)        settle_cnt <= 4'(KEY_LAT - 1);
      else if (settle_cnt != '0)  settle_cnt <= settle_cnt - 4'd1;
      if (capture_pending) pending_key <= bus.i_key;
      if (load_key_input)        core_key <= bus.i_key;
      else if (load_key_pending) core_key <= pending_key;
    end
  end

  assign key_hs    = bus.i_key_valid & key_ready;
  assign occupancy = OW'(inflight) + OW'(fifo_count);
  assign issue_en  = (state == RUN) & ~key_hs & (occupancy < OW'(DEPTH));

  // Contended cycles go to whoever was not served last; a lone requester always wins.
  always_comb begin
    grant = ~last_grant;
    if (bus.i_req0_valid != bus.i_req1_valid) grant = bus.i_req1_valid;
  end

  assign accept      = issue_en & (grant ? bus.i_req1_valid : bus.i_req0_valid);
  assign accept_data = grant ? bus.i_req1_data : bus.i_req0_data;
  assign accept_dir  = grant ? bus.i_req1_dir  : bus.i_req0_dir;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      core_data  <= '0;
      last_grant <= 1'b1;
      tag_valid  <= '0;
      tag_id     <= '0;
      tag_dir    <= '0;
      inflight   <= '0;
    end else begin
      tag_valid <= {tag_valid[LAT-1:0], accept};
      tag_id    <= {tag_id[LAT-1:0], grant};
      tag_dir   <= {tag_dir[LAT-1:0], accept_dir};
      if (accept) begin
        core_data  <= accept_data;
        last_grant <= grant;
      end
      if (accept && !push)      inflight <= inflight + IW'(1);
      else if (!accept && push) inflight <= inflight - IW'(1);
    end
  end

  assign push      = tag_valid[LAT];
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid & bus.i_rsp_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; validity comes from the reset pointers and count.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= '{id: tag_id[LAT], data: bus.i_core_result};
  end

  // Issue throttling reserves a FIFO slot for every in-flight block.
  assert property (@(posedge i_clk) disable iff (i_reset)
                   !(push && (fifo_count == (AW+1)'(DEPTH))));

  assign bus.o_req0_ready = issue_en & ~grant;
  assign bus.o_req1_ready = issue_en &  grant;
  assign bus.o_key_ready  = key_ready;
  assign bus.o_core_data  = core_data;
  assign bus.o_core_key   = core_key;
  assign bus.o_core_dir   = tag_valid[LAT] & tag_dir[LAT];
  assign bus.o_rsp_valid  = rsp_valid;
  assign bus.o_rsp_id     = fifo_mem[rd_ptr].id;
  assign bus.o_rsp_data   = fifo_mem[rd_ptr].data;

endmodule

// File: tb/tb_serpent_arbiter.sv
// Randomized bench for serpent_arbiter: a keyed stand-in core with LAT cycles of delay,
// and a transaction-level scoreboard of expected responses per accepted block.
module tb_serpent_arbiter;
  localparam int LAT     = 34;
  localparam int DEPTH   = 64;
  localparam int KEY_LAT = 2;

  typedef struct packed {
    logic         id;
    logic [127:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serpent_arbiter_if bus ();

  serpent_arbiter #(.LAT(LAT), .DEPTH(DEPTH), .KEY_LAT(KEY_LAT)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: expected responses, loaded key, last winner, blocks not yet popped.
  rsp_t         exp_q[$];
  logic [255:0] m_key = '0;
  int           m_last = 1;
  int           outstanding = 0;
  int           acc_total = 0;

  // Keyed, invertible stand-in for the cipher: encrypt and decrypt differ for any key.
  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [255:0] k,
                                           input logic dir);
    logic [127:0] t;
    if (dir) begin
      t = d ^ k[127:0];
      return {t[120:0], t[127:121]} + k[255:128];
    end
    t = d - k[255:128];
    t = {t[6:0], t[127:7]};
    return t ^ k[127:0];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  // Cipher core model: o_core_data/o_core_key become i_core_result LAT cycles later.
  logic [127:0] pd [LAT];
  logic [255:0] pk [LAT];
  always @(posedge clk) begin
    pd[0] <= bus.o_core_data;
    pk[0] <= bus.o_core_key;
    for (int i = 1; i < LAT; i++) begin
      pd[i] <= pd[i-1];
      pk[i] <= pk[i-1];
    end
  end
  assign bus.i_core_result = core_fn(pd[LAT-1], pk[LAT-1], bus.o_core_dir);

  // Transaction monitor and scoreboard.
  logic mon_id;
  rsp_t mon_want;
  rsp_t mon_got;
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.o_req0_ready && bus.o_req1_ready) begin
        errors++;
        $display("FAIL one_ready: got both readies high, want at most one");
      end
      if ((bus.i_req0_valid && bus.o_req0_ready) || (bus.i_req1_valid && bus.o_req1_ready)) begin
        mon_id = bus.i_req1_valid && bus.o_req1_ready;
        if (bus.i_req0_valid && bus.i_req1_valid) begin
          checks++;
          if (int'(mon_id) == m_last) begin
            errors++;
            $display("FAIL rr_grant: got %0d, want %0d", mon_id, 1 - m_last);
          end
        end
        checks++;
        if (outstanding >= DEPTH) begin
          errors++;
          $display("FAIL capacity: accepted with %0d outstanding, want < %0d", outstanding, DEPTH);
        end
        mon_want = mon_id ? {1'b1, core_fn(bus.i_req1_data, m_key, bus.i_req1_dir)}
                          : {1'b0, core_fn(bus.i_req0_data, m_key, bus.i_req0_dir)};
        exp_q.push_back(mon_want);
        m_last = int'(mon_id);
        outstanding++;
        acc_total++;
      end
      if (bus.i_key_valid && bus.o_key_ready) m_key = bus.i_key;
      if (bus.o_rsp_valid && bus.i_rsp_ready) begin
        mon_got = {bus.o_rsp_id, bus.o_rsp_data};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got id=%0d data=%h, want no response", mon_got.id, mon_got.data);
        end else begin
          mon_want = exp_q.pop_front();
          if (mon_got !== mon_want) begin
            errors++;
            $display("FAIL rsp_data: got id=%0d %h, want id=%0d %h",
                     mon_got.id, mon_got.data, mon_want.id, mon_want.data);
          end
          outstanding--;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs(input bit v0, input bit v1);
    bus.i_req0_valid = v0;
    bus.i_req1_valid = v1;
    bus.i_req0_data  = rand128();
    bus.i_req1_data  = rand128();
    bus.i_req0_dir   = 1'($urandom_range(0, 1));
    bus.i_req1_dir   = 1'($urandom_range(0, 1));
  endtask

  task automatic model_reset();
    exp_q.delete();
    outstanding = 0;
    m_last      = 1;
    m_key       = '0;
  endtask

  task automatic load_key(input logic [255:0] k);
    int n = 0;
    bus.i_key       = k;
    bus.i_key_valid = 1'b1;
    while (n < 300) begin
      @(negedge clk);
      if (bus.o_key_ready) break;
      tick();
      n++;
    end
    tick();
    bus.i_key_valid = 1'b0;
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL key_accept: key never accepted within %0d cycles", n);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    drive_reqs(1'b0, 1'b0);
    bus.i_rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.o_rsp_valid) && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.o_rsp_valid) begin
      errors++;
      $display("FAIL %s_drain: got %0d responses still pending, want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    drive_reqs(1'b0, 1'b0);
    bus.i_key_valid = 1'b0;
    bus.i_key       = '0;
    bus.i_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.o_req0_ready !== 1'b0 || bus.o_req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b%b, want 00", bus.o_req0_ready, bus.o_req1_ready);
    end
    checks++;
    if (bus.o_rsp_valid !== 1'b0 || bus.o_core_dir !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: got valid=%b dir=%b, want 0 0", bus.o_rsp_valid, bus.o_core_dir);
    end
    checks++;
    if (bus.o_core_data !== '0 || bus.o_core_key !== '0) begin
      errors++;
      $display("FAIL reset_core: got data=%h key=%h, want zeros", bus.o_core_data, bus.o_core_key);
    end
    checks++;
    if (bus.o_key_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_key_ready: got %b, want 1", bus.o_key_ready);
    end
    rst = 1'b0;
    drive_reqs(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.o_req0_ready || bus.o_req1_ready) begin
        errors++;
        $display("FAIL nokey_issue: got ready %b%b without key, want 00", bus.o_req0_ready, bus.o_req1_ready);
      end
      tick();
    end
    drive_reqs(1'b0, 1'b0);
  endtask

  task automatic test_first_block();
    int n;
    bus.i_key       = '0;
    bus.i_key_valid = 1'b1;
    tick();
    bus.i_key_valid  = 1'b0;
    bus.i_req0_valid = 1'b1;
    bus.i_req0_dir   = 1'b1;
    bus.i_req0_data  = '0;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (bus.o_req0_ready) break;
      tick();
      n++;
    end
    checks++;
    if (n != KEY_LAT) begin
      errors++;
      $display("FAIL first_ready_delay: got %0d cycles, want %0d", n, KEY_LAT);
    end
    tick();
    bus.i_req0_valid = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (bus.o_rsp_valid) break;
      tick();
      n++;
    end
    checks++;
    if (n != LAT + 1) begin
      errors++;
      $display("FAIL first_rsp_latency: got %0d cycles, want %0d", n, LAT + 1);
    end
    checks++;
    if (bus.o_rsp_id !== 1'b0 || bus.o_rsp_data !== core_fn('0, '0, 1'b1)) begin
      errors++;
      $display("FAIL first_rsp_value: got id=%0d %h, want id=0 %h",
               bus.o_rsp_id, bus.o_rsp_data, core_fn('0, '0, 1'b1));
    end
    wait_drain("first_block");
  endtask

  task automatic test_round_robin();
    int g_exp = 1 - m_last;
    int got;
    bus.i_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_reqs(1'b1, 1'b1);
      @(negedge clk);
      got = bus.o_req1_ready ? 1 : (bus.o_req0_ready ? 0 : -1);
      checks++;
      if (got != g_exp) begin
        errors++;
        $display("FAIL rr_sequence[%0d]: got grant %0d, want %0d", i, got, g_exp);
      end
      g_exp = 1 - g_exp;
      tick();
    end
    wait_drain("round_robin");
  endtask

  task automatic test_throughput();
    int base = acc_total;
    bus.i_rsp_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_reqs(1'b1, 1'($urandom_range(0, 1)));
      tick();
    end
    checks++;
    if (acc_total - base != 100) begin
      errors++;
      $display("FAIL throughput: got %0d accepts in 100 cycles, want 100", acc_total - base);
    end
    wait_drain("throughput");
  endtask

  task automatic test_backpressure();
    int base = acc_total;
    bus.i_rsp_ready = 1'b0;
    for (int i = 0; i < 150; i++) begin
      drive_reqs(1'b1, 1'b0);
      tick();
    end
    checks++;
    if (acc_total - base != DEPTH) begin
      errors++;
      $display("FAIL full_accepts: got %0d, want %0d", acc_total - base, DEPTH);
    end
    @(negedge clk);
    checks++;
    if (bus.o_req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got %b, want 0", bus.o_req0_ready);
    end
    tick();
    bus.i_rsp_ready = 1'b1;
    tick();
    bus.i_rsp_ready = 1'b0;
    base = acc_total;
    for (int i = 0; i < 60; i++) begin
      drive_reqs(1'b1, 1'b0);
      tick();
    end
    checks++;
    if (acc_total - base != 1) begin
      errors++;
      $display("FAIL pop_one_accept: got %0d accepts after one pop, want 1", acc_total - base);
    end
    wait_drain("backpressure");
  endtask

  task automatic test_key_change();
    int base = acc_total;
    int n = 0;
    int key_cycle = -1;
    bit stray_issue = 1'b0;
    logic [255:0] old_key = m_key;
    logic [255:0] new_key = rand256();
    bus.i_rsp_ready = 1'b1;
    while (acc_total - base < 10 && n < 100) begin
      drive_reqs(1'b1, 1'($urandom_range(0, 1)));
      tick();
      n++;
    end
    bus.i_key       = new_key;
    bus.i_key_valid = 1'b1;
    drive_reqs(1'b1, 1'b1);
    tick();
    bus.i_key_valid = 1'b0;
    n = 0;
    while (n < 300) begin
      if (acc_total - base != 10) stray_issue = 1'b1;
      drive_reqs(1'b1, 1'b1);
      @(negedge clk);
      if (key_cycle < 0 && bus.o_core_key !== old_key) begin
        key_cycle = n;
        checks++;
        if (outstanding != 0 || bus.o_core_key !== new_key) begin
          errors++;
          $display("FAIL key_early: got key %h with %0d outstanding, want %h with 0",
                   bus.o_core_key, outstanding, new_key);
        end
      end
      if (bus.o_req0_ready || bus.o_req1_ready) break;
      tick();
      n++;
    end
    checks++;
    if (stray_issue) begin
      errors++;
      $display("FAIL key_drain_issue: got issue during key change, want none");
    end
    checks++;
    if (key_cycle < 0 || n - key_cycle != KEY_LAT) begin
      errors++;
      $display("FAIL key_settle: got resume %0d cycles after key load (load at %0d), want %0d",
               n - key_cycle, key_cycle, KEY_LAT);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      drive_reqs(1'($urandom_range(0, 1)), 1'b1);
      tick();
    end
    wait_drain("key_change");
  endtask

  task automatic test_mixed_dir();
    int base = acc_total;
    int n = 0;
    bus.i_rsp_ready = 1'b1;
    bus.i_req1_valid = 1'b0;
    while (acc_total - base < 8 && n < 100) begin
      bus.i_req0_valid = 1'b1;
      bus.i_req0_dir   = ((acc_total - base) % 2 == 0);
      bus.i_req0_data  = rand128();
      tick();
      n++;
    end
    checks++;
    if (acc_total - base != 8) begin
      errors++;
      $display("FAIL mixed_dir_accepts: got %0d, want 8", acc_total - base);
    end
    wait_drain("mixed_dir");
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 400; i++) begin
      drive_reqs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bus.i_rsp_ready = ($urandom_range(0, 3) != 0);
      bus.i_key_valid = ($urandom_range(0, 49) == 0);
      bus.i_key       = rand256();
      tick();
    end
    bus.i_key_valid = 1'b0;
    wait_drain("random");
  endtask

  task automatic test_reset_midstream();
    int base = acc_total;
    int n = 0;
    int leaks = 0;
    int got;
    bus.i_rsp_ready = 1'b1;
    while (acc_total - base < 20 && n < 100) begin
      drive_reqs(1'b1, 1'($urandom_range(0, 1)));
      tick();
      n++;
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.o_req0_ready || bus.o_req1_ready || bus.o_rsp_valid || bus.o_core_dir) begin
      errors++;
      $display("FAIL midreset_flags: got r0=%b r1=%b rsp=%b dir=%b, want 0",
               bus.o_req0_ready, bus.o_req1_ready, bus.o_rsp_valid, bus.o_core_dir);
    end
    checks++;
    if (bus.o_core_data !== '0 || bus.o_core_key !== '0) begin
      errors++;
      $display("FAIL midreset_core: got data=%h key=%h, want zeros", bus.o_core_data, bus.o_core_key);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      drive_reqs(1'b1, 1'b1);
      @(negedge clk);
      if (bus.o_rsp_valid || bus.o_req0_ready || bus.o_req1_ready) leaks++;
      tick();
    end
    checks++;
    if (leaks != 0) begin
      errors++;
      $display("FAIL stale_after_reset: got %0d active cycles, want 0", leaks);
    end
    drive_reqs(1'b0, 1'b0);
    load_key(rand256());
    n = 0;
    got = -1;
    while (n < 50) begin
      drive_reqs(1'b1, 1'b1);
      @(negedge clk);
      if (bus.o_req0_ready || bus.o_req1_ready) begin
        got = bus.o_req1_ready ? 1 : 0;
        break;
      end
      tick();
      n++;
    end
    checks++;
    if (got != 0) begin
      errors++;
      $display("FAIL reset_pointer: got first grant %0d, want 0", got);
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      drive_reqs(1'b1, 1'b1);
      tick();
    end
    wait_drain("reset_midstream");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_first_block();
    test_round_robin();
    test_throughput();
    test_backpressure();
    test_key_change();
    test_mixed_dir();
    test_random_traffic();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
